// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Purpose:
//   Bit-serial adder. Computes i_a + i_b + i_cin one bit per clock, LSB
//   first, through a single full-adder cell and a 1-bit carry register.
//   An accepted start latches the operands. WIDTH clocks later o_done
//   pulses for one cycle, with o_sum/o_cout holding the result. The result
//   stays on the outputs until the next accepted start.
//
// Ports:
//   i_clk    sole clock, rising edge
//   i_rst    synchronous, active-high reset
//   i_start  request to begin an addition (only looked at while idle)
//   i_a      operand A, latched on accepted start
//   i_b      operand B, latched on accepted start
//   i_cin    carry-in, latched on accepted start
//   o_busy   high while an addition is in progress (SHIFT or DONE)
//   o_done   single-cycle pulse marking o_sum/o_cout valid
//   o_sum    registered sum, (a+b+cin) mod 2^WIDTH
//   o_cout   registered carry-out of the full WIDTH-bit addition
// ---------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic               w_di;
    logic               w_cnext;

    // Single full-adder cell acting on the operand LSBs and the carry register.
    assign w_di    = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_cnext = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));

    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs. DONE always falls back to IDLE.
    // Any start seen in SHIFT or DONE is therefore ignored.
    always_comb begin
        w_next = r_state;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Datapath. Each result bit enters at the sum MSB and the sum shifts
    // right, so after WIDTH shifts bit 0 sits at the LSB. The sum is left
    // alone in IDLE, which keeps the previous result visible until the
    // next accepted start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_carry <= i_cin;
                r_cnt   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sum   <= {w_di, r_sum[WIDTH-1:1]};
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_cnext;
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_cout <= w_cnext;
                end
            end
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Purpose:
//   Self-checking bench for serial_adder (WIDTH=8). Each scenario task drives
//   its own stimulus and compares against a reference result. The reference
//   is plain integer addition of the operands, taken at WIDTH+1 bits.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int BUDGET = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total;
    int bad;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the full (WIDTH+1)-bit value of a+b+cin.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y,
                                             input logic c);
        return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    endfunction

    // Issues one addition; must be called just after a falling edge.
    // Operands are scrambled while busy. Returns the edge index of done
    // (k = edges after the start edge), the busy-cycle count, the done-pulse
    // count and the observed {cout,sum}. It returns in the first idle cycle
    // after done, so a following call forms a back-to-back start.
    task automatic run_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, output int doneLat, output int busyCnt,
                           output int doneCnt, output logic [WIDTH:0] result);
        doneLat = -1;
        busyCnt = 0;
        doneCnt = 0;
        result  = '0;
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
            end
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneLat < 0) begin
                    doneLat = k;
                    result = {cout, sum};
                end
            end
            if (doneLat >= 0 && k == doneLat + 1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_state cycle %0d: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                         i, busy, done, sum, cout);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        int lat, bc, dc;
        logic [WIDTH:0] r;
        run_add(8'h35, 8'h4A, 1'b0, lat, bc, dc, r);
        total++;
        if (lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL basic_latency: got %0d, want %0d", lat, WIDTH);
        end
        total++;
        if (r !== 9'h07F) begin
            bad++;
            $display("[TB] FAIL basic_result: got %h, want 07f", r);
        end
        total++;
        if (bc !== WIDTH + 1) begin
            bad++;
            $display("[TB] FAIL basic_busy_cycles: got %0d, want %0d", bc, WIDTH + 1);
        end
        total++;
        if (dc !== 1) begin
            bad++;
            $display("[TB] FAIL basic_done_count: got %0d, want 1", dc);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== 9'h07F) begin
            bad++;
            $display("[TB] FAIL basic_hold: busy=%b done=%b result=%h, want 0 0 07f",
                     busy, done, {cout, sum});
        end
    endtask

    task automatic test_wrap();
        int lat, bc, dc;
        logic [WIDTH:0] r;
        run_add(8'hFF, 8'h00, 1'b1, lat, bc, dc, r);
        total++;
        if (r !== 9'h100 || lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL wrap_ff_00_1: got %h lat %0d, want 100 lat %0d", r, lat, WIDTH);
        end
        run_add(8'hFF, 8'hFF, 1'b1, lat, bc, dc, r);
        total++;
        if (r !== 9'h1FF || lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL wrap_ff_ff_1: got %h lat %0d, want 1ff lat %0d", r, lat, WIDTH);
        end
    endtask

    task automatic test_ignore_busy();
        int dc, lat;
        logic [WIDTH:0] r;
        dc = 0;
        lat = -1;
        r = '0;
        a = 8'h01;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin
                a = 8'h80;
                b = 8'h80;
                cin = 1'b1;
            end
            if (done) begin
                dc++;
                if (lat < 0) begin
                    lat = k;
                    r = {cout, sum};
                end
            end
        end
        total++;
        if (dc !== 1) begin
            bad++;
            $display("[TB] FAIL ignore_done_count: got %0d, want 1", dc);
        end
        total++;
        if (r !== 9'h002 || lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL ignore_result: got %h lat %0d, want 002 lat %0d", r, lat, WIDTH);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_idle_after: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int dc, lat, bc;
        logic [WIDTH:0] r;
        dc = 0;
        a = 8'h77;
        b = 8'h66;
        cin = 1'b1;
        start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            start = 1'b0;
            rst = (k == 3);
            if (done) dc++;
        end
        total++;
        if (dc !== 0) begin
            bad++;
            $display("[TB] FAIL reset_mid_done: got %0d pulses, want 0", dc);
        end
        total++;
        if (busy !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_outputs: busy=%b sum=%h cout=%b, want 0 00 0",
                     busy, sum, cout);
        end
        run_add(8'h10, 8'h20, 1'b0, lat, bc, dc, r);
        total++;
        if (r !== 9'h030 || lat !== WIDTH) begin
            bad++;
            $display("[TB] FAIL reset_mid_restart: got %h lat %0d, want 030 lat %0d", r, lat, WIDTH);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc;
        logic [WIDTH:0] r;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] x, y;
        logic c;
        for (int n = 0; n < 1000; n++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            c = 1'($urandom);
            exp = model(x, y, c);
            run_add(x, y, c, lat, bc, dc, r);
            total++;
            if (lat !== WIDTH) begin
                bad++;
                $display("[TB] FAIL b2b_latency #%0d: got %0d, want %0d", n, lat, WIDTH);
            end
            total++;
            if (r !== exp) begin
                bad++;
                $display("[TB] FAIL b2b_result #%0d: %h+%h+%b got %h, want %h", n, x, y, c, r, exp);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
